// File: rtl/arp_eth_rx_wide.sv
// ARP frame receiver with a parameterised payload width.
// Takes an Ethernet header handshake and its payload stream, extracts the 28-byte
// ARP header, and presents the decoded fields with a valid/ready handshake.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   s_eth_hdr_*                   Ethernet header handshake and fields
//   s_eth_payload_axis_*          payload AXI-Stream (lane 0 earliest on the wire)
//   m_frame_valid/ready, m_*      decoded frame handshake and fields
//   busy, error_*                 status and one-cycle error pulses
module arp_eth_rx_wide #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int CHECK_TYPES = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,

  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [15:0]           m_arp_htype,
  output logic [15:0]           m_arp_ptype,
  output logic [7:0]            m_arp_hlen,
  output logic [7:0]            m_arp_plen,
  output logic [15:0]           m_arp_oper,
  output logic [47:0]           m_arp_sha,
  output logic [31:0]           m_arp_spa,
  output logic [47:0]           m_arp_tha,
  output logic [31:0]           m_arp_tpa,

  output logic                  busy,
  output logic                  error_header_early_termination,
  output logic                  error_invalid_header
);

  localparam int          HDR_BYTES = 28;
  localparam int unsigned HDR_W     = 8 * HDR_BYTES;
  localparam int unsigned PTR_W     = 6;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {IDLE, READ_HEADER, WAIT_LAST} state_t;

  state_t             state_q, state_next;
  logic [PTR_W-1:0]   ptr_q, ptr_next, sum;
  logic [CNT_W-1:0]   beat_cnt;
  logic [HDR_W-1:0]   hdr_q, hdr_next;
  logic               hdr_ready_q, hdr_ready_next;
  logic               tready_q, tready_next;
  logic               frame_valid_q, frame_valid_next;
  logic               busy_q;
  logic               err_early_q, err_early_next;
  logic               err_inv_q, err_inv_next;
  logic               beat_accept, hdr_full, hdr_ok;
  logic [47:0]        dest_mac_q, src_mac_q;
  logic [15:0]        eth_type_q;

  // Next-state, byte merge and frame verdict
  always_comb begin
    state_next       = state_q;
    ptr_next         = ptr_q;
    hdr_next         = hdr_q;
    hdr_ready_next   = 1'b0;
    tready_next      = 1'b0;
    frame_valid_next = frame_valid_q && !m_frame_ready;
    err_early_next   = 1'b0;
    err_inv_next     = 1'b0;
    beat_accept      = s_eth_payload_axis_tvalid && tready_q;

    beat_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_cnt = beat_cnt + CNT_W'(s_eth_payload_axis_tkeep[i]);
    end
    sum      = ptr_q + PTR_W'(beat_cnt);
    hdr_full = (sum >= PTR_W'(HDR_BYTES));

    // Header byte k arrives on lane i when the running count equals k-i; byte 0 sits at the MSB
    if (beat_accept) begin
      for (int k = 0; k < HDR_BYTES; k++) begin
        for (int i = 0; i < KEEP_WIDTH; i++) begin
          if ((k >= i) && s_eth_payload_axis_tkeep[i] && (ptr_q == PTR_W'(k - i))) begin
            hdr_next[8*(HDR_BYTES-1-k) +: 8] = s_eth_payload_axis_tdata[8*i +: 8];
          end
        end
      end
    end

    // Judged on the merged header so bytes arriving with tlast are included
    hdr_ok = (hdr_next[191:184] == 8'd6) && (hdr_next[183:176] == 8'd4) &&
             ((CHECK_TYPES == 0) ||
              ((hdr_next[223:208] == 16'h0001) && (hdr_next[207:192] == 16'h0800)));

    unique case (state_q)
      IDLE: begin
        if (s_eth_hdr_valid && hdr_ready_q) begin
          state_next  = READ_HEADER;
          ptr_next    = '0;
          tready_next = 1'b1;
        end else begin
          hdr_ready_next = !frame_valid_next;
        end
      end
      READ_HEADER, WAIT_LAST: begin
        tready_next = 1'b1;
        if (beat_accept) begin
          ptr_next = hdr_full ? PTR_W'(HDR_BYTES) : sum;
          if (s_eth_payload_axis_tlast) begin
            state_next  = IDLE;
            tready_next = 1'b0;
            if (!hdr_full) begin
              err_early_next = 1'b1;
            end else if (!hdr_ok) begin
              err_inv_next = 1'b1;
            end else if (!s_eth_payload_axis_tuser) begin
              frame_valid_next = 1'b1;
            end
          end else if (hdr_full) begin
            state_next = WAIT_LAST;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hdr_ready_q   <= 1'b0;
      tready_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_early_q   <= 1'b0;
      err_inv_q     <= 1'b0;
    end else begin
      state_q       <= state_next;
      ptr_q         <= ptr_next;
      hdr_ready_q   <= hdr_ready_next;
      tready_q      <= tready_next;
      frame_valid_q <= frame_valid_next;
      busy_q        <= (state_next != IDLE);
      err_early_q   <= err_early_next;
      err_inv_q     <= err_inv_next;
    end
  end

  // Datapath registers, not reset
  always_ff @(posedge clk) begin
    hdr_q <= hdr_next;
    if (s_eth_hdr_valid && hdr_ready_q) begin
      dest_mac_q <= s_eth_dest_mac;
      src_mac_q  <= s_eth_src_mac;
      eth_type_q <= s_eth_type;
    end
  end

  assign s_eth_hdr_ready                = hdr_ready_q;
  assign s_eth_payload_axis_tready      = tready_q;
  assign m_frame_valid                  = frame_valid_q;
  assign busy                           = busy_q;
  assign error_header_early_termination = err_early_q;
  assign error_invalid_header           = err_inv_q;

  assign m_eth_dest_mac = dest_mac_q;
  assign m_eth_src_mac  = src_mac_q;
  assign m_eth_type     = eth_type_q;

  // Byte 0 of the header occupies hdr_q[223:216]
  assign m_arp_htype = hdr_q[223:208];
  assign m_arp_ptype = hdr_q[207:192];
  assign m_arp_hlen  = hdr_q[191:184];
  assign m_arp_plen  = hdr_q[183:176];
  assign m_arp_oper  = hdr_q[175:160];
  assign m_arp_sha   = hdr_q[159:112];
  assign m_arp_spa   = hdr_q[111:80];
  assign m_arp_tha   = hdr_q[79:32];
  assign m_arp_tpa   = hdr_q[31:0];

endmodule

// File: tb/tb_arp_eth_rx_wide.sv
// Directed bench for arp_eth_rx_wide at 8-, 64- and 32-bit widths, plus an
// 8-bit instance with type checking disabled.
module tb_arp_eth_rx_wide;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] dmac, smac;
  logic [15:0] etype;

  logic        hv [4], tv [4], tl [4], tu [4], fr [4];
  logic [63:0] td [4];
  logic [7:0]  tk [4];
  logic        hr [4], trdy [4], fv [4], bsy [4], ee [4], ei [4];
  logic [47:0] o_dmac [4], o_smac [4], o_sha [4], o_tha [4];
  logic [15:0] o_etype [4], o_htype [4], o_ptype [4], o_oper [4];
  logic [7:0]  o_hlen [4], o_plen [4];
  logic [31:0] o_spa [4], o_tpa [4];

  logic [7:0]  fb [64];
  int          nchk = 0;
  int          npass = 0;
  int          st;

  always #5 clk = ~clk;

  // Instance 0: 8-bit, 1: 64-bit, 2: 32-bit, 3: 8-bit without type checks
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DW = (g == 1) ? 64 : ((g == 2) ? 32 : 8);
    localparam int CT = (g == 3) ? 0 : 1;
    arp_eth_rx_wide #(.DATA_WIDTH(DW), .CHECK_TYPES(CT)) u_dut (
      .clk                            (clk),
      .rst                            (rst),
      .s_eth_hdr_valid                (hv[g]),
      .s_eth_hdr_ready                (hr[g]),
      .s_eth_dest_mac                 (dmac),
      .s_eth_src_mac                  (smac),
      .s_eth_type                     (etype),
      .s_eth_payload_axis_tdata       (td[g][DW-1:0]),
      .s_eth_payload_axis_tkeep       (tk[g][DW/8-1:0]),
      .s_eth_payload_axis_tvalid      (tv[g]),
      .s_eth_payload_axis_tready      (trdy[g]),
      .s_eth_payload_axis_tlast       (tl[g]),
      .s_eth_payload_axis_tuser       (tu[g]),
      .m_frame_valid                  (fv[g]),
      .m_frame_ready                  (fr[g]),
      .m_eth_dest_mac                 (o_dmac[g]),
      .m_eth_src_mac                  (o_smac[g]),
      .m_eth_type                     (o_etype[g]),
      .m_arp_htype                    (o_htype[g]),
      .m_arp_ptype                    (o_ptype[g]),
      .m_arp_hlen                     (o_hlen[g]),
      .m_arp_plen                     (o_plen[g]),
      .m_arp_oper                     (o_oper[g]),
      .m_arp_sha                      (o_sha[g]),
      .m_arp_spa                      (o_spa[g]),
      .m_arp_tha                      (o_tha[g]),
      .m_arp_tpa                      (o_tpa[g]),
      .busy                           (bsy[g]),
      .error_header_early_termination (ee[g]),
      .error_invalid_header           (ei[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ARP request: sha 02:11:22:33:44:55, spa C0A80164, tha 0, tpa C0A80180, zero padding after
  task automatic build(input logic [15:0] ht, input logic [15:0] pt,
                       input logic [7:0] hl, input logic [7:0] pl);
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    fb[0] = ht[15:8]; fb[1] = ht[7:0];
    fb[2] = pt[15:8]; fb[3] = pt[7:0];
    fb[4] = hl;       fb[5] = pl;
    fb[6] = 8'h00;    fb[7] = 8'h01;
    fb[8] = 8'h02; fb[9] = 8'h11; fb[10] = 8'h22; fb[11] = 8'h33; fb[12] = 8'h44; fb[13] = 8'h55;
    fb[14] = 8'hC0; fb[15] = 8'hA8; fb[16] = 8'h01; fb[17] = 8'h64;
    fb[24] = 8'hC0; fb[25] = 8'hA8; fb[26] = 8'h01; fb[27] = 8'h80;
  endtask

  // Header handshake then payload beats of nb bytes; stops early after maxbeats beats
  task automatic send(input int u, input int nb, input int len, input bit bad,
                      input int maxbeats, output int stalls);
    int guard;
    int nbeat;
    stalls = 0;
    guard  = 0;
    hv[u]  = 1'b1;
    while (!hr[u] && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("hdr_ready_wait", 64'(guard < 50), 64'd1);
    @(posedge clk); #1;
    hv[u] = 1'b0;
    chk("busy_in_frame", 64'(bsy[u]), 64'd1);
    nbeat = 0;
    for (int i = 0; i < len && nbeat < maxbeats; i += nb) begin
      td[u] = '0;
      tk[u] = '0;
      for (int j = 0; j < nb; j++) begin
        if (i + j < len) begin
          td[u][8*j +: 8] = fb[i+j];
          tk[u][j]        = 1'b1;
        end
      end
      tl[u] = (i + nb >= len);
      tu[u] = bad && (i + nb >= len);
      tv[u] = 1'b1;
      guard = 0;
      while (!trdy[u] && guard < 50) begin @(posedge clk); #1; guard++; end
      chk("tready_wait", 64'(guard < 50), 64'd1);
      stalls += guard;
      @(posedge clk); #1;
      nbeat++;
    end
    tv[u] = 1'b0;
    tl[u] = 1'b0;
    tu[u] = 1'b0;
  endtask

  task automatic check_fields(input int u, input logic [15:0] pt);
    chk("htype", 64'(o_htype[u]), 64'h0001);
    chk("ptype", 64'(o_ptype[u]), 64'(pt));
    chk("hlen",  64'(o_hlen[u]),  64'd6);
    chk("plen",  64'(o_plen[u]),  64'd4);
    chk("oper",  64'(o_oper[u]),  64'd1);
    chk("sha",   64'(o_sha[u]),   64'h021122334455);
    chk("spa",   64'(o_spa[u]),   64'hC0A80164);
    chk("tha",   64'(o_tha[u]),   64'h0);
    chk("tpa",   64'(o_tpa[u]),   64'hC0A80180);
    chk("dmac",  64'(o_dmac[u]),  64'hFFFFFFFFFFFF);
    chk("smac",  64'(o_smac[u]),  64'h02AABBCCDDEE);
    chk("etype", 64'(o_etype[u]), 64'h0806);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    dmac  = 48'hFFFFFFFFFFFF;
    smac  = 48'h02AABBCCDDEE;
    etype = 16'h0806;
    for (int u = 0; u < 4; u++) begin
      hv[u] = 1'b0; tv[u] = 1'b0; tl[u] = 1'b0; tu[u] = 1'b0; fr[u] = 1'b1;
      td[u] = '0;   tk[u] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      chk("rst_hdr_ready", 64'(hr[u]),   64'd0);
      chk("rst_tready",    64'(trdy[u]), 64'd0);
      chk("rst_valid",     64'(fv[u]),   64'd0);
      chk("rst_busy",      64'(bsy[u]),  64'd0);
      chk("rst_err_early", 64'(ee[u]),   64'd0);
      chk("rst_err_inv",   64'(ei[u]),   64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("hdr_ready_after_rst", 64'(hr[0]), 64'd1);

    // 8-bit good request
    build(16'h0001, 16'h0800, 8'd6, 8'd4);
    send(0, 1, 28, 1'b0, 99, st);
    chk("w8_valid", 64'(fv[0]), 64'd1);
    chk("w8_hdr_ready_low", 64'(hr[0]), 64'd0);
    chk("w8_busy_done", 64'(bsy[0]), 64'd0);
    check_fields(0, 16'h0800);
    @(posedge clk); #1;
    chk("w8_valid_clear", 64'(fv[0]), 64'd0);
    chk("w8_hdr_ready_back", 64'(hr[0]), 64'd1);

    // 64-bit with 18 padding bytes, 6 beats
    send(1, 8, 46, 1'b0, 99, st);
    chk("w64_valid", 64'(fv[1]), 64'd1);
    chk("w64_stalls", 64'(st), 64'd0);
    check_fields(1, 16'h0800);
    @(posedge clk); #1;

    // 32-bit early tlast at byte 20
    send(2, 4, 20, 1'b0, 99, st);
    chk("w32_early_pulse", 64'(ee[2]), 64'd1);
    chk("w32_early_valid", 64'(fv[2]), 64'd0);
    @(posedge clk); #1;
    chk("w32_early_end", 64'(ee[2]), 64'd0);
    chk("w32_early_valid2", 64'(fv[2]), 64'd0);

    // hlen 8
    build(16'h0001, 16'h0800, 8'd8, 8'd4);
    send(0, 1, 28, 1'b0, 99, st);
    chk("hlen8_err", 64'(ei[0]), 64'd1);
    chk("hlen8_valid", 64'(fv[0]), 64'd0);
    @(posedge clk); #1;
    chk("hlen8_err_end", 64'(ei[0]), 64'd0);

    // ptype 86DD with and without type checks
    build(16'h0001, 16'h86DD, 8'd6, 8'd4);
    send(0, 1, 28, 1'b0, 99, st);
    chk("ptype_err", 64'(ei[0]), 64'd1);
    chk("ptype_valid", 64'(fv[0]), 64'd0);
    @(posedge clk); #1;
    chk("ptype_err_end", 64'(ei[0]), 64'd0);
    send(3, 1, 28, 1'b0, 99, st);
    chk("nochk_valid", 64'(fv[3]), 64'd1);
    chk("nochk_err", 64'(ei[3]), 64'd0);
    check_fields(3, 16'h86DD);
    @(posedge clk); #1;

    // tuser drop then a normal frame
    build(16'h0001, 16'h0800, 8'd6, 8'd4);
    send(0, 1, 28, 1'b1, 99, st);
    chk("drop_valid", 64'(fv[0]), 64'd0);
    chk("drop_err_early", 64'(ee[0]), 64'd0);
    chk("drop_err_inv", 64'(ei[0]), 64'd0);
    @(posedge clk); #1;
    chk("drop_valid2", 64'(fv[0]), 64'd0);
    send(0, 1, 28, 1'b0, 99, st);
    chk("after_drop_valid", 64'(fv[0]), 64'd1);
    chk("after_drop_spa", 64'(o_spa[0]), 64'hC0A80164);
    @(posedge clk); #1;

    // Output backpressure for 10 cycles
    fr[0] = 1'b0;
    send(0, 1, 28, 1'b0, 99, st);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(fv[0]), 64'd1);
      chk("bp_hdr_ready", 64'(hr[0]), 64'd0);
      chk("bp_tpa", 64'(o_tpa[0]), 64'hC0A80180);
    end
    fr[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(fv[0]), 64'd0);
    chk("bp_release_hdr_ready", 64'(hr[0]), 64'd1);

    // Reset in the middle of a 64-bit header
    send(1, 8, 46, 1'b0, 2, st);
    chk("mid_busy", 64'(bsy[1]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tready", 64'(trdy[1]), 64'd0);
    chk("mid_rst_busy",   64'(bsy[1]),  64'd0);
    chk("mid_rst_valid",  64'(fv[1]),   64'd0);
    chk("mid_rst_early",  64'(ee[1]),   64'd0);
    chk("mid_rst_inv",    64'(ei[1]),   64'd0);
    chk("mid_rst_hready", 64'(hr[1]),   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_hready", 64'(hr[1]), 64'd1);
    chk("post_rst_early",  64'(ee[1]), 64'd0);
    chk("post_rst_inv",    64'(ei[1]), 64'd0);
    send(1, 8, 46, 1'b0, 99, st);
    chk("post_rst_valid", 64'(fv[1]), 64'd1);
    check_fields(1, 16'h0800);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/arp_eth_rx_wide.md
ARP_ETH_RX_WIDE -- requirements
Module: arp_eth_rx_wide

Interface
REQ-001 DATA_WIDTH, default 8, payload width in bits; SHALL be 8, 16, 32 or 64.
REQ-002 KEEP_WIDTH, default DATA_WIDTH/8, byte lanes; lane 0 (tdata[7:0]) SHALL be the earliest byte on the wire.
REQ-003 CHECK_TYPES, default 1, when 1 SHALL additionally require htype 0x0001 and ptype 0x0800.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_eth_hdr_valid / s_eth_hdr_ready  input / output  1 each  Ethernet header handshake.
REQ-007 s_eth_dest_mac, s_eth_src_mac / s_eth_type  input  48 each / 16  Ethernet header fields.
REQ-008 s_eth_payload_axis_tdata  input  DATA_WIDTH  payload data.
REQ-009 s_eth_payload_axis_tkeep  input  KEEP_WIDTH  byte enables, contiguous from lane 0, all ones except on the tlast beat.
REQ-010 s_eth_payload_axis_tvalid / tready / tlast / tuser  in / out / in / in  1 each  payload AXI-Stream; tuser=1 on tlast marks a bad frame.
REQ-011 m_frame_valid / m_frame_ready  output / input  1 each  decoded-frame handshake.
REQ-012 m_eth_dest_mac, m_eth_src_mac / m_eth_type  output  48 each / 16  captured Ethernet fields.
REQ-013 m_arp_htype, m_arp_ptype, m_arp_oper  output  16 each  ARP fields, big-endian.
REQ-014 m_arp_hlen, m_arp_plen  output  8 each  ARP length fields.
REQ-015 m_arp_sha, m_arp_tha / m_arp_spa, m_arp_tpa  output  48 each / 32 each  ARP addresses; first wire byte SHALL be the MSB.
REQ-016 busy, error_header_early_termination, error_invalid_header  output  1 each  status.

Function
REQ-017 The header SHALL be 28 bytes at payload offsets 0-27: htype 0-1, ptype 2-3, hlen 4, plen 5, oper 6-7, sha 8-13, spa 14-17, tha 18-23, tpa 24-27.
REQ-018 A byte counter SHALL advance by popcount(tkeep) per accepted beat, saturating at 28; the header occupies ceil(28/KEEP_WIDTH) beats, and any beat may carry header bytes and trailing padding together.
REQ-019 States: IDLE, READ_HEADER, WAIT_LAST. IDLE->READ_HEADER on hdr handshake, capturing the Ethernet fields in that cycle. READ_HEADER->WAIT_LAST when byte 27 is accepted without tlast. Any state->IDLE when the tlast beat is accepted.
REQ-020 s_eth_hdr_ready SHALL be registered, high only in IDLE with no pending output, and low the cycle after a hdr handshake.
REQ-021 tready SHALL be registered, high in READ_HEADER and WAIT_LAST, and low the cycle after the tlast beat.
REQ-022 On tlast with fewer than 28 bytes received, SHALL pulse error_header_early_termination for 1 cycle and not assert m_frame_valid.
REQ-023 On tlast with a complete header, validity SHALL be judged on values including bytes of the same beat: hlen==6, plen==4, plus type checks if CHECK_TYPES. Failure SHALL pulse error_invalid_header for 1 cycle.
REQ-024 A valid header with tuser=1 on tlast SHALL be dropped silently; no error, no m_frame_valid.
REQ-025 Otherwise m_frame_valid SHALL rise the cycle after the tlast beat; outputs SHALL stay stable until m_frame_ready, then valid clears in that cycle.
REQ-026 hdr_ready SHALL reassert in the same cycle m_frame_valid clears, giving 1 cycle of frame backpressure.
REQ-027 busy SHALL be registered (state_next != IDLE).

Reset
REQ-028 On rst: state IDLE, counter 0, s_eth_hdr_ready, tready, m_frame_valid, busy and both errors 0; field registers keep their values (datapath not reset); hdr_ready rises the first cycle after rst deasserts.
REQ-029 rst mid-frame SHALL abandon the frame with no error pulse; remaining beats are not accepted until a new hdr handshake.

Verification
REQ-030 DATA_WIDTH=8, 28-byte request (htype 1, ptype 0800, 6/4, oper 1, spa C0A80164, tpa C0A80180): m_frame_valid 1 cycle after tlast, fields exact.
REQ-031 DATA_WIDTH=64, same frame plus 18 padding bytes (6 beats, last tkeep 0x3F): identical fields, and no stall during the beats.
REQ-032 DATA_WIDTH=32, tlast at byte 20: early-termination pulse exactly 1 cycle; m_frame_valid stays 0.
REQ-033 hlen=8, then separately ptype=86DD with CHECK_TYPES=1: error_invalid_header pulse each; ptype=86DD with CHECK_TYPES=0 yields a valid frame.
REQ-034 Good frame with tuser=1: no output, no errors; next good frame decodes normally.
REQ-035 m_frame_ready held 0 for 10 cycles: outputs stable, hdr_ready 0 throughout; rst asserted mid-header: all flags 0, then a clean frame passes.
